// File: rtl/ysyx_25060170_fetch_ctrl.sv
// ysyx_25060170_fetch_ctrl
// Instruction fetch sequencer for the IFU. Owns the fetch PC, keeps at most one
// request outstanding on the instruction memory port, and hands {pc, inst} to ID
// through a valid/ready handshake. Redirects from LS, EX and ID (highest priority
// first) retarget the PC. A response that belongs to a superseded request is
// swallowed instead of being presented.
module ysyx_25060170_fetch_ctrl #(
  parameter int              PC_W     = 32,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_pc_jump,
  input  logic [PC_W-1:0]   id_pc_i,
  input  logic              ie_pc_jump,
  input  logic [PC_W-1:0]   ie_pc_i,
  input  logic              ls_pc_jump,
  input  logic [PC_W-1:0]   ls_pc_i,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              id_ready,
  output logic [PC_W-1:0]   if_pc,
  output logic [INST_W-1:0] if_inst
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};
  localparam logic [PC_W-1:0] PC_STEP    = {{(PC_W-3){1'b0}}, 3'd4};

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic              drop;
  logic              redir_pend;
  logic [PC_W-1:0]   redir_pc;

  logic              jump;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   next_seq_pc;

  // Merge the three redirect sources; the oldest stage (LS) wins, and targets are word aligned.
  always_comb begin
    jump        = ls_pc_jump | ie_pc_jump | id_pc_jump;
    target      = '0;
    if (ls_pc_jump) begin
      target = ls_pc_i & ALIGN_MASK;
    end else if (ie_pc_jump) begin
      target = ie_pc_i & ALIGN_MASK;
    end else begin
      target = id_pc_i & ALIGN_MASK;
    end
    next_seq_pc = if_pc + PC_STEP;
  end

  // A redirect in the same cycle kills the presented instruction, so ID never sees a stale one.
  always_comb begin
    if_valid = (state == HOLD) && !jump;
  end

  assign imem_req_addr = pc;

  // Fetch sequencer: issue, wait for the response, present it, then pick the next PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      imem_req_valid <= 1'b0;
      pc             <= RESET_PC;
      if_pc          <= '0;
      if_inst        <= '0;
      drop           <= 1'b0;
      redir_pend     <= 1'b0;
      redir_pc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          state          <= REQ;
          imem_req_valid <= 1'b1;
          pc             <= jump ? target : RESET_PC;
        end

        REQ: begin
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
            drop           <= redir_pend | jump;
            if (jump) begin
              redir_pc <= target;
            end
          end else if (jump) begin
            // The address must stay stable while the request is pending, so park the redirect.
            redir_pend <= 1'b1;
            redir_pc   <= target;
          end
        end

        WAIT: begin
          if (imem_rsp_valid) begin
            if (drop || jump) begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
              pc             <= jump ? target : redir_pc;
              drop           <= 1'b0;
              redir_pend     <= 1'b0;
            end else begin
              state   <= HOLD;
              if_inst <= imem_rsp_data;
              if_pc   <= pc;
            end
          end else if (jump) begin
            drop     <= 1'b1;
            redir_pc <= target;
          end
        end

        HOLD: begin
          if (jump) begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
            pc             <= target;
          end else if (id_ready) begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
            pc             <= next_seq_pc;
          end
        end

        default: begin
          state          <= IDLE;
          imem_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25060170_fetch_ctrl.sv
// tb_ysyx_25060170_fetch_ctrl
// Scoreboard bench for the fetch controller: expected request addresses and
// expected transfers to ID are queued as stimulus is applied and popped when
// the DUT issues a request or completes a transfer. A small memory model
// answers each accepted request after a programmable delay.
module tb_ysyx_25060170_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        id_pc_jump;
  logic [31:0] id_pc_i;
  logic        ie_pc_jump;
  logic [31:0] ie_pc_i;
  logic        ls_pc_jump;
  logic [31:0] ls_pc_i;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_xfer_q[$];

  int          rsp_delay   = 1;
  int          mem_cnt     = 0;
  logic [31:0] mem_addr    = '0;
  logic        accept_seen = 1'b0;
  logic [31:0] accept_addr = '0;

  ysyx_25060170_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_pc_jump     (id_pc_jump),
    .id_pc_i        (id_pc_i),
    .ie_pc_jump     (ie_pc_jump),
    .ie_pc_i        (ie_pc_i),
    .ls_pc_jump     (ls_pc_jump),
    .ls_pc_i        (ls_pc_i),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction contents are a fixed function of the address so any fetch can be predicted.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse a set of redirect requests for exactly one cycle.
  task automatic applyStimulus(input logic ls, input logic [31:0] ls_t,
                               input logic ie, input logic [31:0] ie_t,
                               input logic id, input logic [31:0] id_t);
    ls_pc_jump = ls; ls_pc_i = ls_t;
    ie_pc_jump = ie; ie_pc_i = ie_t;
    id_pc_jump = id; id_pc_i = id_t;
    step();
    ls_pc_jump = 1'b0;
    ie_pc_jump = 1'b0;
    id_pc_jump = 1'b0;
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    while (!if_valid && n < 100) begin
      step();
      n++;
    end
    checkOutput(tag, {31'd0, if_valid}, 32'd1);
  endtask

  // Request monitor: every accepted request must match the next expected address.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        checkOutput("req_expected", {31'd0, exp_req_q.size() > 0}, 32'd1);
        if (exp_req_q.size() > 0) begin
          checkOutput("req_addr", imem_req_addr, exp_req_q.pop_front());
        end
        accept_seen = 1'b1;
        accept_addr = imem_req_addr;
      end
    end
  end

  // Transfer monitor: every handshake with ID must match the next expected instruction.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && if_valid && id_ready) begin
        checkOutput("xfer_expected", {31'd0, exp_xfer_q.size() > 0}, 32'd1);
        if (exp_xfer_q.size() > 0) begin
          e = exp_xfer_q.pop_front();
          checkOutput("xfer_pc", if_pc, e);
          checkOutput("xfer_inst", if_inst, inst_of(e));
        end
      end
    end
  end

  // Memory model: answers an accepted request rsp_delay cycles later with a one-cycle response.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      step();
      imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        mem_cnt     = 0;
        accept_seen = 1'b0;
      end else begin
        if (accept_seen) begin
          accept_seen = 1'b0;
          mem_cnt     = rsp_delay;
          mem_addr    = accept_addr;
        end
        if (mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_addr);
          end
        end
      end
    end
  end

  // Watchdog so a stuck DUT still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b0;
    ls_pc_jump = 1'b0; ls_pc_i = '0;
    ie_pc_jump = 1'b0; ie_pc_i = '0;
    id_pc_jump = 1'b0; id_pc_i = '0;

    step();
    step();
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_req_addr", imem_req_addr, 32'h8000_0000);
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_if_pc", if_pc, 32'd0);
    checkOutput("rst_if_inst", if_inst, 32'd0);

    // First fetch after reset, then a sequential fetch.
    exp_req_q.push_back(32'h8000_0000);
    rst_n = 1'b1;
    waitValid("t1_valid");
    checkOutput("t1_pc", if_pc, 32'h8000_0000);
    exp_xfer_q.push_back(32'h8000_0000);
    exp_req_q.push_back(32'h8000_0004);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;

    // ID back-pressure: presented instruction holds and nothing new is requested.
    waitValid("t2_valid");
    for (int i = 0; i < 5; i++) begin
      checkOutput("t2_hold_valid", {31'd0, if_valid}, 32'd1);
      checkOutput("t2_hold_pc", if_pc, 32'h8000_0004);
      checkOutput("t2_hold_inst", if_inst, inst_of(32'h8000_0004));
      checkOutput("t2_no_req", {31'd0, imem_req_valid}, 32'd0);
      step();
    end
    exp_xfer_q.push_back(32'h8000_0004);
    exp_req_q.push_back(32'h8000_0008);
    rsp_delay = 3;
    id_ready  = 1'b1;
    step();
    id_ready = 1'b0;

    // EX redirect while waiting: in-flight response is dropped.
    step();
    checkOutput("t3_in_wait", {31'd0, imem_req_valid}, 32'd0);
    exp_req_q.push_back(32'h8000_0100);
    applyStimulus(1'b0, '0, 1'b1, 32'h8000_0100, 1'b0, '0);
    waitValid("t3_valid");
    checkOutput("t3_pc", if_pc, 32'h8000_0100);
    checkOutput("t3_inst", if_inst, inst_of(32'h8000_0100));

    // Three simultaneous redirects in HOLD with ID ready: LS wins and kills the transfer.
    rsp_delay = 1;
    exp_req_q.push_back(32'h8000_0200);
    ls_pc_jump = 1'b1; ls_pc_i = 32'h8000_0200;
    ie_pc_jump = 1'b1; ie_pc_i = 32'h8000_0300;
    id_pc_jump = 1'b1; id_pc_i = 32'h8000_0400;
    id_ready   = 1'b1;
    #1;
    checkOutput("t4_kill", {31'd0, if_valid}, 32'd0);
    step();
    ls_pc_jump = 1'b0;
    ie_pc_jump = 1'b0;
    id_pc_jump = 1'b0;
    id_ready   = 1'b0;

    // Redirect while the request is stalled: address holds, aligned target follows.
    waitValid("t5_pre_valid");
    checkOutput("t5_pre_pc", if_pc, 32'h8000_0200);
    imem_req_ready = 1'b0;
    exp_xfer_q.push_back(32'h8000_0200);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    checkOutput("t5_req_valid", {31'd0, imem_req_valid}, 32'd1);
    checkOutput("t5_req_addr", imem_req_addr, 32'h8000_0204);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 32'h8000_0042);
    checkOutput("t5_addr_held", imem_req_addr, 32'h8000_0204);
    step();
    checkOutput("t5_addr_held2", imem_req_addr, 32'h8000_0204);
    checkOutput("t5_valid_held", {31'd0, imem_req_valid}, 32'd1);
    exp_req_q.push_back(32'h8000_0204);
    exp_req_q.push_back(32'h8000_0040);
    imem_req_ready = 1'b1;
    waitValid("t5_valid");
    checkOutput("t5_pc", if_pc, 32'h8000_0040);

    // PC wrap at the top of the address space, then reset while waiting.
    exp_req_q.push_back(32'hFFFF_FFFC);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, '0);
    waitValid("t6_valid");
    checkOutput("t6_pc", if_pc, 32'hFFFF_FFFC);
    exp_xfer_q.push_back(32'hFFFF_FFFC);
    exp_req_q.push_back(32'h0000_0000);
    rsp_delay = 3;
    id_ready  = 1'b1;
    step();
    id_ready = 1'b0;
    checkOutput("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
    step();
    checkOutput("t6_in_wait", {31'd0, imem_req_valid}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("t6_rst_req_addr", imem_req_addr, 32'h8000_0000);
    checkOutput("t6_rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("t6_rst_if_pc", if_pc, 32'd0);
    checkOutput("t6_rst_if_inst", if_inst, 32'd0);
    step();
    step();
    rsp_delay = 1;
    exp_req_q.push_back(32'h8000_0000);
    rst_n = 1'b1;
    waitValid("t6_restart_valid");
    checkOutput("t6_restart_pc", if_pc, 32'h8000_0000);

    step();
    checkOutput("req_q_drained", exp_req_q.size(), 32'd0);
    checkOutput("xfer_q_drained", exp_xfer_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
